loom_axil_ctrl_regs: RTL and testbench

LOOM_AXIL_CTRL_REGS -- requirements
Module: loom_axil_ctrl_regs

---
 rtl/loom_axil_ctrl_regs.sv | 245 ++++++++++++++++++++++++
 tb/tb_loom_axil_ctrl_regs.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loom_axil_ctrl_regs.sv
// loom_axil_ctrl_regs: AXI-Lite control/status register block.
//
// Register map (decoded on addr[7:2]):
//   0x00 ID         RO  constant ID_VALUE
//   0x04 SCRATCH    RW  byte strobes honoured
//   0x08 IRQ_STATUS R/W1C
//   0x0C IRQ_ENABLE RW
//   0x10 IRQ_SET    WO  write-1-to-set status, reads 0
//   0x14 FINISH     bit0 write-1 sets sticky finish_o
//   0x18 CYCLE_LO   RO  low counter word; snapshots high word into shadow
//   0x1C CYCLE_HI   RO  shadow captured by the last CYCLE_LO read
// Unmapped offsets answer SLVERR.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   s_axil_aw*/w*/b*        AXI-Lite write channels
//   s_axil_ar*/r*           AXI-Lite read channels
//   irq_src_i               event lines, rising edge sets status
//   irq_o                   status & enable
//   finish_o                sticky end-of-test request
module loom_axil_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned N_IRQ      = 16,
  parameter logic [31:0] ID_VALUE   = 32'h4C4F_4F4D
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr_i,
  input  logic                  s_axil_awvalid_i,
  output logic                  s_axil_awready_o,
  input  logic [31:0]           s_axil_wdata_i,
  input  logic [3:0]            s_axil_wstrb_i,
  input  logic                  s_axil_wvalid_i,
  output logic                  s_axil_wready_o,
  output logic [1:0]            s_axil_bresp_o,
  output logic                  s_axil_bvalid_o,
  input  logic                  s_axil_bready_i,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr_i,
  input  logic                  s_axil_arvalid_i,
  output logic                  s_axil_arready_o,
  output logic [31:0]           s_axil_rdata_o,
  output logic [1:0]            s_axil_rresp_o,
  output logic                  s_axil_rvalid_o,
  input  logic                  s_axil_rready_i,
  input  logic [N_IRQ-1:0]      irq_src_i,
  output logic [N_IRQ-1:0]      irq_o,
  output logic                  finish_o
);

  localparam logic [5:0] IdxId     = 6'd0;
  localparam logic [5:0] IdxScratch = 6'd1;
  localparam logic [5:0] IdxStatus = 6'd2;
  localparam logic [5:0] IdxEnable = 6'd3;
  localparam logic [5:0] IdxSet    = 6'd4;
  localparam logic [5:0] IdxFinish = 6'd5;
  localparam logic [5:0] IdxCycLo  = 6'd6;
  localparam logic [5:0] IdxCycHi  = 6'd7;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // Write channel skid state
  logic             r_aw_held;
  logic [5:0]       r_aw_idx;
  logic             r_w_held;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_bvalid;
  logic [1:0]       r_bresp;

  // Read channel state
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  // Register file
  logic [31:0]      r_scratch;
  logic [N_IRQ-1:0] r_irq_status;
  logic [N_IRQ-1:0] r_irq_enable;
  logic [N_IRQ-1:0] r_irq_src_prev;
  logic             r_finish;
  logic [63:0]      r_cycle;
  logic [31:0]      r_cyc_hi_shadow;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_wr_commit;
  logic [5:0]       w_wr_idx;
  logic [31:0]      w_wr_data;
  logic [3:0]       w_wr_strb;
  logic             w_wr_mapped;
  logic             w_ar_hs;
  logic [5:0]       w_ar_idx;
  logic [31:0]      w_rd_data;
  logic             w_rd_err;
  logic [N_IRQ-1:0] w_irq_set;
  logic [N_IRQ-1:0] w_irq_clr;
  logic             w_unused;

  // Address bits outside [7:2] are deliberately ignored by the decoder.
  assign w_unused = ^{s_axil_awaddr_i[ADDR_WIDTH-1:8], s_axil_awaddr_i[1:0],
                      s_axil_araddr_i[ADDR_WIDTH-1:8], s_axil_araddr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  assign s_axil_awready_o = !r_aw_held && !r_bvalid;
  assign s_axil_wready_o  = !r_w_held && !r_bvalid;
  assign s_axil_bvalid_o  = r_bvalid;
  assign s_axil_bresp_o   = r_bresp;

  assign w_aw_hs = s_axil_awvalid_i && s_axil_awready_o;
  assign w_w_hs  = s_axil_wvalid_i && s_axil_wready_o;

  // Commit as soon as both halves are available, held or arriving this cycle.
  assign w_wr_commit = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_idx    = r_aw_held ? r_aw_idx : s_axil_awaddr_i[7:2];
  assign w_wr_data   = r_w_held ? r_w_data : s_axil_wdata_i;
  assign w_wr_strb   = r_w_held ? r_w_strb : s_axil_wstrb_i;
  assign w_wr_mapped = (w_wr_idx[5:3] == 3'b000);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
    end else begin
      if (w_wr_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_idx  <= s_axil_awaddr_i[7:2];
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= s_axil_wdata_i;
          r_w_strb <= s_axil_wstrb_i;
        end
      end
      if (w_wr_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_mapped ? RespOkay : RespSlverr;
      end else if (s_axil_bready_i) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  assign s_axil_arready_o = !r_rvalid;
  assign s_axil_rvalid_o  = r_rvalid;
  assign s_axil_rdata_o   = r_rdata;
  assign s_axil_rresp_o   = r_rresp;

  assign w_ar_hs  = s_axil_arvalid_i && s_axil_arready_o;
  assign w_ar_idx = s_axil_araddr_i[7:2];

  // Mux reads current register state, so a same-edge write is not visible.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_ar_idx)
      IdxId:      w_rd_data = ID_VALUE;
      IdxScratch: w_rd_data = r_scratch;
      IdxStatus:  w_rd_data[N_IRQ-1:0] = r_irq_status;
      IdxEnable:  w_rd_data[N_IRQ-1:0] = r_irq_enable;
      IdxSet:     w_rd_data = '0;
      IdxFinish:  w_rd_data[0] = r_finish;
      IdxCycLo:   w_rd_data = r_cycle[31:0];
      IdxCycHi:   w_rd_data = r_cyc_hi_shadow;
      default:    w_rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_err ? RespSlverr : RespOkay;
      end else if (s_axil_rready_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  always_comb begin
    w_irq_set = irq_src_i & ~r_irq_src_prev;
    w_irq_clr = '0;
    if (w_wr_commit && (w_wr_idx == IdxSet)) begin
      w_irq_set = w_irq_set | w_wr_data[N_IRQ-1:0];
    end
    if (w_wr_commit && (w_wr_idx == IdxStatus)) begin
      w_irq_clr = w_wr_data[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scratch       <= '0;
      r_irq_status    <= '0;
      r_irq_enable    <= '0;
      r_irq_src_prev  <= '0;
      r_finish        <= 1'b0;
      r_cycle         <= '0;
      r_cyc_hi_shadow <= '0;
    end else begin
      r_cycle        <= r_cycle + 64'd1;
      r_irq_src_prev <= irq_src_i;
      // Set is applied after clear so a coincident set wins.
      r_irq_status   <= (r_irq_status & ~w_irq_clr) | w_irq_set;
      if (w_ar_hs && (w_ar_idx == IdxCycLo)) begin
        r_cyc_hi_shadow <= r_cycle[63:32];
      end
      if (w_wr_commit) begin
        if (w_wr_idx == IdxScratch) begin
          for (int b = 0; b < 4; b++) begin
            if (w_wr_strb[b]) r_scratch[8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
        if (w_wr_idx == IdxEnable) r_irq_enable <= w_wr_data[N_IRQ-1:0];
        if ((w_wr_idx == IdxFinish) && w_wr_data[0]) r_finish <= 1'b1;
      end
    end
  end

  assign irq_o    = r_irq_status & r_irq_enable;
  assign finish_o = r_finish;

endmodule

// File: tb/tb_loom_axil_ctrl_regs.sv
// Directed bench for loom_axil_ctrl_regs: a table of single AXI-Lite
// transactions plus hand-written sequences for skid ordering, back-pressure,
// interrupt priority, same-edge read/write, finish and reset behaviour.
module tb_loom_axil_ctrl_regs;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [19:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [19:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [15:0] irq_src = '0;
  logic [15:0] irq;
  logic        finish;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned tb_cyc = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) tb_cyc <= tb_cyc + 1;

  loom_axil_ctrl_regs dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .s_axil_awaddr_i (awaddr),
    .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i  (wdata),
    .s_axil_wstrb_i  (wstrb),
    .s_axil_wvalid_i (wvalid),
    .s_axil_wready_o (wready),
    .s_axil_bresp_o  (bresp),
    .s_axil_bvalid_o (bvalid),
    .s_axil_bready_i (bready),
    .s_axil_araddr_i (araddr),
    .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o  (rdata),
    .s_axil_rresp_o  (rresp),
    .s_axil_rvalid_o (rvalid),
    .s_axil_rready_i (rready),
    .irq_src_i       (irq_src),
    .irq_o           (irq),
    .finish_o        (finish)
  );

  typedef struct {
    logic        is_wr;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk_i);
    check("rst_ctl", {31'b0, bvalid}, 32'd0);
    check("rst_flags", {26'b0, rvalid, awready, wready, arready, finish, 1'b0}, 32'b011100);
    check("rst_irq", {16'b0, irq}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic axi_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit awr, wr;
    int n = 0;
    @(negedge clk_i);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      awr = awready; wr = wready;
      @(posedge clk_i);
      if (awr) aw_done = 1'b1;
      if (wr)  w_done = 1'b1;
      @(negedge clk_i);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!bvalid) check("b_timeout", 32'd0, 32'd1);
    resp = bresp;
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [19:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int unsigned hc);
    int n = 0;
    @(negedge clk_i);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(negedge clk_i);
    arvalid = 1'b0;
    hc = tb_cyc;
    check("r_latency", {31'b0, rvalid}, 32'd1);
    n = 0;
    while (!rvalid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    d = rdata; r = rresp;
    rready = 1'b1;
    @(negedge clk_i);
    rready = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  logic [1:0]  rs;
  int unsigned c1, c2;

  initial begin
    // Table: op, addr, wdata, wstrb, expected rdata (reads), expected resp
    vecs.push_back('{1'b0, 20'h00000, 32'h0,        4'h0, 32'h4C4F4F4D, 2'b00});
    vecs.push_back('{1'b1, 20'h00004, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00004, 32'h0,        4'h0, 32'hFFFFFFFF, 2'b00});
    vecs.push_back('{1'b1, 20'h00004, 32'h00000000, 4'h4, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00004, 32'h0,        4'h0, 32'hFF00FFFF, 2'b00});
    vecs.push_back('{1'b0, 20'hAB106, 32'h0,        4'h0, 32'hFF00FFFF, 2'b00});
    vecs.push_back('{1'b1, 20'h0000C, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h0000C, 32'h0,        4'h0, 32'h0000FFFF, 2'b00});
    vecs.push_back('{1'b1, 20'h00000, 32'h12345678, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00000, 32'h0,        4'h0, 32'h4C4F4F4D, 2'b00});
    vecs.push_back('{1'b1, 20'h00040, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b10});
    vecs.push_back('{1'b0, 20'h0003C, 32'h0,        4'h0, 32'h0,        2'b10});
    vecs.push_back('{1'b0, 20'h00004, 32'h0,        4'h0, 32'hFF00FFFF, 2'b00});
    vecs.push_back('{1'b1, 20'h00010, 32'h00010003, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00008, 32'h0,        4'h0, 32'h00000003, 2'b00});
    vecs.push_back('{1'b0, 20'h00010, 32'h0,        4'h0, 32'h0,        2'b00});
    vecs.push_back('{1'b1, 20'h00008, 32'h00000001, 4'h0, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00008, 32'h0,        4'h0, 32'h00000002, 2'b00});
    vecs.push_back('{1'b1, 20'h00008, 32'h00000002, 4'hF, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00008, 32'h0,        4'h0, 32'h0,        2'b00});
    vecs.push_back('{1'b0, 20'h00014, 32'h0,        4'h0, 32'h0,        2'b00});

    // Reset from time 0 with output checks inside reset.
    do_reset();

    // W three cycles ahead of AW into SCRATCH with partial strobes.
    @(negedge clk_i);
    wdata = 32'hA5A5_1234; wstrb = 4'b0011; wvalid = 1'b1;
    check("w_first_ready", {31'b0, wready}, 32'd1);
    @(negedge clk_i);
    wvalid = 1'b0;
    check("w_held_ready", {30'b0, awready, wready}, 32'b10);
    repeat (3) @(negedge clk_i);
    check("w_only_no_b", {31'b0, bvalid}, 32'd0);
    awaddr = 20'h00004; awvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0;
    check("w_first_b", {29'b0, bvalid, bresp}, {29'b0, 1'b1, 2'b00});
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    repeat (2) @(negedge clk_i);
    check("w_first_single_b", {31'b0, bvalid}, 32'd0);
    axi_read(20'h00004, rd, rs, c1);
    check("w_first_readback", rd, 32'h0000_1234);

    // Table-driven single transactions.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        check($sformatf("vec%0d_bresp", i), {30'b0, rs}, {30'b0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, rd, rs, c1);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), {30'b0, rs}, {30'b0, vecs[i].exp_resp});
      end
    end

    // Interrupts: masking, edge set, set-beats-clear, plain clear.
    axi_write(20'h0000C, 32'h1, 4'hF, rs);
    axi_write(20'h00010, 32'h2, 4'hF, rs);
    check("irq_masked", {16'b0, irq}, 32'd0);
    @(negedge clk_i);
    irq_src[0] = 1'b1;
    @(negedge clk_i);
    check("irq_edge", {16'b0, irq}, 32'h1);
    irq_src[0] = 1'b0;
    @(negedge clk_i);
    awaddr = 20'h00008; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    irq_src[0] = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    check("irq_set_wins_b", {31'b0, bvalid}, 32'd1);
    check("irq_set_wins", {16'b0, irq}, 32'h1);
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    axi_read(20'h00008, rd, rs, c1);
    check("irq_status_both", rd, 32'h3);
    axi_write(20'h00008, 32'h3, 4'hF, rs);
    check("irq_cleared", {16'b0, irq}, 32'd0);
    irq_src = '0;

    // B back-pressure for five cycles.
    @(negedge clk_i);
    awaddr = 20'h00004; awvalid = 1'b1; wdata = 32'h1111_2222; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (5) begin
      check("b_stall", {28'b0, bvalid, bresp, awready, wready}, {28'b0, 1'b1, 2'b00, 2'b00});
      @(negedge clk_i);
    end
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    check("b_release", {29'b0, bvalid, awready, wready}, 32'b011);

    // Read and write to SCRATCH on the same edge: read sees old value.
    @(negedge clk_i);
    awaddr = 20'h00004; awvalid = 1'b1; wdata = 32'h3333_4444; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 20'h00004; arvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_same_edge_v", {30'b0, rvalid, bvalid}, 32'b11);
    check("rw_same_edge_old", rdata, 32'h1111_2222);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk_i);
    rready = 1'b0; bready = 1'b0;
    axi_read(20'h00004, rd, rs, c1);
    check("rw_same_edge_new", rd, 32'h3333_4444);

    // Finish: zero write is ignored, one sets the next cycle, sticky afterwards.
    axi_write(20'h00014, 32'h0, 4'hF, rs);
    check("finish_zero", {31'b0, finish}, 32'd0);
    @(negedge clk_i);
    awaddr = 20'h00014; awvalid = 1'b1; wdata = 32'h1; wstrb = 4'h0; wvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0; wvalid = 1'b0;
    check("finish_set", {31'b0, finish}, 32'd1);
    bready = 1'b1;
    @(negedge clk_i);
    bready = 1'b0;
    axi_write(20'h00014, 32'h0, 4'hF, rs);
    check("finish_sticky", {31'b0, finish}, 32'd1);
    axi_read(20'h00014, rd, rs, c1);
    check("finish_read", rd, 32'd1);

    // Cycle counter tracks elapsed cycles; high shadow stays 0 this early.
    axi_read(20'h00018, rd, rs, c1);
    axi_read(20'h0001B, rd2, rs, c2);
    check("cycle_delta", rd2 - rd, c2 - c1);
    check("cycle_lo_resp", {30'b0, rs}, 32'd0);
    axi_read(20'h0001C, rd, rs, c1);
    check("cycle_hi", rd, 32'd0);

    // Event line held high across reset yields one edge; state is cleared.
    irq_src = 16'h0020;
    do_reset();
    check("finish_after_rst", {31'b0, finish}, 32'd0);
    axi_read(20'h00008, rd, rs, c1);
    check("irq_across_rst", rd, 32'h20);
    axi_read(20'h00004, rd, rs, c1);
    check("scratch_after_rst", rd, 32'd0);
    irq_src = '0;

    // Reset with AW held: the held address must be discarded.
    @(negedge clk_i);
    awaddr = 20'h00004; awvalid = 1'b1;
    @(negedge clk_i);
    awvalid = 1'b0;
    check("aw_held", {31'b0, awready}, 32'd0);
    do_reset();
    @(negedge clk_i);
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk_i);
    wvalid = 1'b0;
    repeat (3) @(negedge clk_i);
    check("aw_dropped", {30'b0, bvalid, awready}, 32'b01);
    axi_read(20'h00004, rd, rs, c1);
    check("aw_dropped_scratch", rd, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
